// File: rtl/scan_sequencer.sv
// 4-bit scan index generator with prescaled auto-advance, single-step and optional ping-pong sweep.
// Optional feature: define SCAN_BOUNCE_EN to honour the bounce input (ping-pong mode).
module scan_sequencer #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             dir,
    input  logic             bounce,
    input  logic [DIV_W-1:0] div,
    output logic [3:0]       idx,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] PC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [DIV_W-1:0] pc_q, pc_d;
    logic             step_q, step_d;
    logic [3:0]       idx_q, idx_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             adv;
    logic             up;
    logic             bmode;

`ifdef SCAN_BOUNCE_EN
    logic bnc_q, bnc_d;
    logic bd_q, bd_d;
    logic bnc_enter;
    logic dir_eff;
`else
    logic bounce_unused;
    assign bounce_unused = bounce;
`endif

    always_comb begin
        state_d = run ? ST_RUN : ST_STOP;
        step_d  = step;
        pc_d    = '0;
        adv     = 1'b0;

        if (state_q == ST_RUN) begin
            // >= so a div lowered below the running count fires at once
            if (pc_q >= div) begin
                adv = 1'b1;
            end else begin
                pc_d = pc_q + PC_ONE;
            end
        end else if (step && !step_q) begin
            adv = 1'b1;
        end

        up    = ~dir;
        bmode = 1'b0;
`ifdef SCAN_BOUNCE_EN
        bnc_d     = bounce;
        bd_d      = bd_q;
        bnc_enter = bounce & ~bnc_q;
        dir_eff   = bnc_enter ? dir : bd_q;
        if (bounce) begin
            bmode = 1'b1;
            if (idx_q == 4'd0) begin
                up = 1'b1;
            end else if (idx_q == 4'd15) begin
                up = 1'b0;
            end else begin
                up = ~dir_eff;
            end
            if (bnc_enter) begin
                bd_d = dir;
            end
        end
`endif

        idx_d  = idx_q;
        tick_d = adv;
        wrap_d = 1'b0;
        if (adv) begin
            idx_d = up ? (idx_q + 4'd1) : (idx_q - 4'd1);
            if (bmode) begin
                wrap_d = (idx_d == 4'd0) || (idx_d == 4'd15);
`ifdef SCAN_BOUNCE_EN
                if (idx_d == 4'd15) begin
                    bd_d = 1'b1;
                end else if (idx_d == 4'd0) begin
                    bd_d = 1'b0;
                end else begin
                    bd_d = ~up;
                end
`endif
            end else begin
                wrap_d = up ? (idx_q == 4'd15) : (idx_q == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STOP;
            pc_q    <= '0;
            step_q  <= 1'b0;
            idx_q   <= 4'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef SCAN_BOUNCE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bnc_q <= 1'b0;
            bd_q  <= 1'b0;
        end else begin
            bnc_q <= bnc_d;
            bd_q  <= bd_d;
        end
    end
`endif

    assign idx  = idx_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: a sweep-level reference model queues expected outputs per edge.
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        dir = 1'b0;
    logic        bounce = 1'b0;
    logic [23:0] div = 24'd0;
    logic [3:0]  idx;
    logic        tick;
    logic        wrap;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [3:0] idx;
        logic       tick;
        logic       wrap;
    } exp_t;

    exp_t q[$];

    // reference model state
    bit m_run = 0;
    int m_pc = 0;
    bit m_stp = 0;
    int m_idx = 0;
    bit m_bnc = 0;
    int m_ph = 0;   // position in the 30-step ping-pong cycle

    scan_sequencer #(.DIV_W(24)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .dir(dir),
        .bounce(bounce), .div(div), .idx(idx), .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_run = 0; m_pc = 0; m_stp = 0; m_idx = 0; m_bnc = 0; m_ph = 0;
                q.delete();
            end else begin
                bit adv;
                bit bval;
                bit wr;
                exp_t e;
                adv = 0;
                wr = 0;
`ifdef SCAN_BOUNCE_EN
                bval = bounce;
`else
                bval = 0;
`endif
                if (m_run) begin
                    if (m_pc >= int'(div)) begin
                        adv = 1;
                        m_pc = 0;
                    end else begin
                        m_pc = m_pc + 1;
                    end
                end else begin
                    m_pc = 0;
                    if (step && !m_stp) adv = 1;
                end
                if (bval && !m_bnc) begin
                    if (!dir) m_ph = m_idx;
                    else m_ph = (m_idx == 0) ? 0 : 30 - m_idx;
                end
                if (adv) begin
                    if (bval) begin
                        m_ph = (m_ph + 1) % 30;
                        m_idx = (m_ph <= 15) ? m_ph : 30 - m_ph;
                        wr = (m_idx == 0) || (m_idx == 15);
                    end else if (dir) begin
                        wr = (m_idx == 0);
                        m_idx = (m_idx + 15) % 16;
                    end else begin
                        wr = (m_idx == 15);
                        m_idx = (m_idx + 1) % 16;
                    end
                end
                m_stp = step;
                m_run = run;
                m_bnc = bval;
                e.idx = 4'(m_idx);
                e.tick = adv;
                e.wrap = wr;
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if (idx !== e.idx || tick !== e.tick || wrap !== e.wrap) begin
                bad++;
                $display("FAIL scan_out t=%0t got idx=%0d tick=%0b wrap=%0b want idx=%0d tick=%0b wrap=%0b",
                         $time, idx, tick, wrap, e.idx, e.tick, e.wrap);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (idx !== 4'd0 || tick !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got idx=%0d tick=%0b wrap=%0b want idx=0 tick=0 wrap=0", idx, tick, wrap);
        end
        run = 1'b0; step = 1'b0; bounce = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_model_idx(input int v);
        int n;
        n = 0;
        while (m_idx != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (m_idx != v) begin
            bad++;
            $display("FAIL wait_idx got %0d want %0d", m_idx, v);
        end
    endtask

    initial begin
        // power-up reset, then idle in STOP
        cyc(2);
        rst = 1'b0;
        cyc(4);

        // linear up, div=3, through 15->0
        dir = 1'b0; div = 24'd3; run = 1'b1;
        cyc(72);

        // fast up until idx 7, then asynchronous reset mid-count
        do_reset();
        div = 24'd0; run = 1'b1;
        wait_model_idx(7);
        do_reset();
        cyc(5);

        // div=0 counting down from 0
        dir = 1'b1; div = 24'd0; run = 1'b1;
        cyc(40);
        run = 1'b0;
        cyc(3);

        // stepping: long hold, then two single-cycle pulses
        do_reset();
        dir = 1'b0;
        step = 1'b1; cyc(10);
        step = 1'b0; cyc(3);
        step = 1'b1; cyc(1);
        step = 1'b0; cyc(2);
        step = 1'b1; cyc(1);
        step = 1'b0; cyc(3);
        // step pulses while running are ignored
        div = 24'd5; run = 1'b1; cyc(2);
        step = 1'b1; cyc(1);
        step = 1'b0; cyc(2);
        step = 1'b1; cyc(1);
        step = 1'b0; cyc(10);
        // run and step on the same edge from STOP
        run = 1'b0; cyc(3);
        run = 1'b1; step = 1'b1; cyc(1);
        step = 1'b0; cyc(12);

        // div lowered mid-count
        do_reset();
        div = 24'd10; run = 1'b1;
        begin
            int n;
            n = 0;
            while (m_pc != 6 && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        div = 24'd2;
        cyc(12);

`ifdef SCAN_BOUNCE_EN
        // ping-pong sweep from 0
        do_reset();
        bounce = 1'b1; div = 24'd0; dir = 1'b0; run = 1'b1;
        cyc(40);
        bounce = 1'b0;
        cyc(5);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) run = ~run;
            step = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) bounce = ~bounce;
            if ($urandom_range(0, 19) == 0) div = 24'($urandom_range(0, 4));
        end
        run = 1'b0; step = 1'b0;
        cyc(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
# scan_sequencer

Free-running or single-stepped 4-bit index generator that drives the 4-to-16 active-low line decoder in the lab LED/segment scan chain. A programmable prescaler sets the scan rate. The index moves up, down or ping-pong across 0..15. Registered strobes flag every index change and every end-of-sweep so downstream logic can synchronise to the scan.

## Interface
- DIV_W, 24, width of the prescaler counter and of the `div` input
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- run  in  1  1 = auto-advance at prescaled rate; 0 = stopped
- step  in  1  single-step request; rising edge (sampled) advances one position while stopped
- dir  in  1  0 = count up, 1 = count down (ignored while bounce mode active)
- bounce  in  1  1 = ping-pong sweep (only effective when SCAN_BOUNCE_EN defined)
- div  in  DIV_W  advance period minus one, in clk cycles
- idx  out  4  current scan index, feeds decoder input
- tick  out  1  one-cycle pulse, high in the cycle after idx changed
- wrap  out  1  one-cycle pulse on end-of-sweep (see Operation)

## Operation
- States: STOP, RUN. STOP→RUN when run=1 sampled; RUN→STOP when run=0 sampled.
- Prescaler `pc` (DIV_W bits): in RUN, increments each cycle; advance fires when pc >= div, pc reloads 0 that edge. Comparison is >= so lowering div mid-count never overshoots. In STOP, pc held 0. Entering RUN starts from pc=0: first advance div+1 cycles after run first sampled high.
- div=0: advance every cycle in RUN.
- Step: internal step_q registers step each edge; step&~step_q in STOP = one advance. Ignored in RUN (step_q still tracks).
- Advance, linear mode: idx ±1 modulo 16 per dir. wrap pulses on 15→0 (up) or 0→15 (down).
- Advance, bounce mode: internal direction bit bd; idx moves per bd; on reaching 15 bd←down, on reaching 0 bd←up, so sequence 0,1..15,14..1,0,1.. with each endpoint emitted once. wrap pulses on the advance that lands on 0 or 15.
- Switching dir mid-run takes effect on the next advance. Entering bounce mode: bd loaded from dir. Leaving bounce mode: resumes linear per dir.
- Reset (any time, including mid-count): idx=0, tick=0, wrap=0, state=STOP, pc=0, step_q=0, bd=up. Outputs return to reset values immediately, asynchronously.

## Timing
- All outputs registered; no combinational input→output path.
- Advance decision made at edge N → idx new value, tick=1, wrap (if applicable) visible after edge N, for exactly one cycle (tick/wrap) before clearing at edge N+1 unless another advance.
- Steady RUN: tick period = div+1 cycles; with div=0 tick stays high continuously and idx changes every cycle.
- Step held high across many cycles produces exactly one advance.
- run and step asserted on the same edge while in STOP: state→RUN, step advance taken (one advance), pc=0.

## Configuration
- SCAN_BOUNCE_EN defined: bounce input honoured, bd register and endpoint reversal logic present.
- Not defined: bounce port kept but ignored, bd removed, sequencer is linear up/down only; wrap only on modulo wrap.

## Test plan
- Reset mid-run with idx=7: assert rst asynchronously → idx=0, tick=0, wrap=0 immediately; after release with run=0, idx stays 0.
- run=1, dir=0, div=3: first tick 4 cycles after run sampled, idx 0→1→2 every 4 cycles; at 15→0 tick and wrap both high one cycle.
- run=1, div=0, dir=1 from idx=0: idx 15,14,13… every cycle, tick constant 1, wrap high only on the 0→15 cycle.
- run=0, step high for 10 cycles then low, then two 1-cycle pulses: idx advances exactly 3 times total; step pulses while run=1 cause no extra advance.
- SCAN_BOUNCE_EN, bounce=1, div=0 from 0: idx 1..15,14..0,1; wrap at arrival on 15 and on 0; no repeated endpoint values.
- div changed 10→2 while pc=6: advance fires at next edge (pc>=div), then period 3 cycles.
